// File: rtl/rv_elastic_buffer.sv
// rv_elastic_buffer
// Ready/valid FIFO elastic buffer with one cycle of latency and no pass-through.
// ready_in and valid_out come from registered state only, so the block
// breaks the combinational handshake paths in both directions.
//
// Ports
//   clk        : single clock, rising edge
//   reset      : asynchronous, active-low reset
//   valid_in   : producer presents data_in
//   ready_in   : buffer can accept an entry this cycle (count != SIZE)
//   data_in    : write payload
//   valid_out  : data_out holds the oldest stored entry (count != 0)
//   ready_out  : consumer takes data_out this cycle
//   data_out   : oldest entry (don't-care while valid_out = 0)
//   count      : number of stored entries, 0..SIZE
module rv_elastic_buffer #(
  parameter int DATAW = 8,
  parameter int SIZE  = 4,
  parameter int ADDRW = $clog2(SIZE)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             valid_in,
  output logic             ready_in,
  input  logic [DATAW-1:0] data_in,
  output logic             valid_out,
  input  logic             ready_out,
  output logic [DATAW-1:0] data_out,
  output logic [ADDRW:0]   count
);

  localparam logic [ADDRW:0] FULL_CNT = (ADDRW+1)'(SIZE);

  logic [DATAW-1:0] mem_q [SIZE];
  logic [ADDRW-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDRW-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDRW:0]   count_q, count_d;
  logic             push, pop;

  assign ready_in  = (count_q != FULL_CNT);
  assign valid_out = (count_q != '0);
  assign data_out  = mem_q[rd_ptr_q];
  assign count     = count_q;

  // When empty, valid_out is low so a simultaneous ready_out cannot pop:
  // the incoming entry only becomes visible after the edge.
  assign push = valid_in && ready_in;
  assign pop  = valid_out && ready_out;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + ADDRW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + ADDRW'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + (ADDRW+1)'(1);
      2'b01:   count_d = count_q - (ADDRW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is deliberately left unreset; the pointers alone define validity.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= data_in;
  end

endmodule
